// File: rtl/acc_cpu_core_if.sv
// Instruction-memory port of acc_cpu_core: read strobe and address out, instruction word back.
// The word returned is the one addressed in the previous cycle.
interface acc_cpu_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) ();
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W+3:0] imem_rdata;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/acc_cpu_core.sv
// Parametrised 3-cycle accumulator CPU (FETCH/DECODE/EXECUTE) with carry/zero flags,
// conditional jumps and a SLEEP state released by the wakeup input.
module acc_cpu_core #(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        ADDR_W   = 6,
    parameter int unsigned        NREGS    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    acc_cpu_core_if.master    imem,
    input  logic              wakeup,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        state,
    output logic              flag_z,
    output logic              flag_c,
    output logic              sleeping,
    output logic              instr_retired
);
    localparam int unsigned SEL_W = $clog2(NREGS);

    typedef enum logic [1:0] {
        StFetch   = 2'b00,
        StDecode  = 2'b01,
        StExecute = 2'b10,
        StSleep   = 2'b11
    } state_e;

    localparam logic [3:0] OpNop = 4'h0, OpLdi = 4'h1, OpLdr = 4'h2, OpStr = 4'h3;
    localparam logic [3:0] OpAdd = 4'h4, OpSub = 4'h5, OpAnd = 4'h6, OpOr  = 4'h7;
    localparam logic [3:0] OpXor = 4'h8, OpNot = 4'h9, OpShl = 4'hA, OpShr = 4'hB;
    localparam logic [3:0] OpJmp = 4'hC, OpJz  = 4'hD, OpJc  = 4'hE, OpSlp = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W+3:0] ir_q;
    logic              z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic              reg_we;
    logic              upd_z;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] operand;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] rsel;
    logic [DATA_W:0]   sum, diff;
    logic [ADDR_W-1:0] pc_inc;

    assign opcode  = ir_q[DATA_W+3:DATA_W];
    assign operand = ir_q[DATA_W-1:0];
    assign sel     = operand[SEL_W-1:0];
    assign target  = operand[ADDR_W-1:0];
    assign rsel    = regs_q[sel];
    assign sum     = {1'b0, acc_q} + {1'b0, rsel};
    // Bit DATA_W of the extended difference is the borrow (acc < R[sel]).
    assign diff    = {1'b0, acc_q} - {1'b0, rsel};
    assign pc_inc  = pc_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        reg_we  = 1'b0;
        upd_z   = 1'b0;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: state_d = StExecute;
            StExecute: begin
                state_d = StFetch;
                pc_d    = pc_inc;
                case (opcode)
                    OpNop: ;
                    OpLdi: begin acc_d = operand;        upd_z = 1'b1; end
                    OpLdr: begin acc_d = rsel;           upd_z = 1'b1; end
                    OpStr: reg_we = 1'b1;
                    OpAdd: begin
                        acc_d = sum[DATA_W-1:0];
                        c_d   = sum[DATA_W];
                        upd_z = 1'b1;
                    end
                    OpSub: begin
                        acc_d = diff[DATA_W-1:0];
                        c_d   = diff[DATA_W];
                        upd_z = 1'b1;
                    end
                    OpAnd: begin acc_d = acc_q & rsel;   upd_z = 1'b1; end
                    OpOr:  begin acc_d = acc_q | rsel;   upd_z = 1'b1; end
                    OpXor: begin acc_d = acc_q ^ rsel;   upd_z = 1'b1; end
                    OpNot: begin acc_d = ~acc_q;         upd_z = 1'b1; end
                    OpShl: begin
                        acc_d = acc_q << 1;
                        c_d   = acc_q[DATA_W-1];
                        upd_z = 1'b1;
                    end
                    OpShr: begin
                        acc_d = acc_q >> 1;
                        c_d   = acc_q[0];
                        upd_z = 1'b1;
                    end
                    OpJmp: pc_d = target;
                    OpJz:  if (z_q) pc_d = target;
                    OpJc:  if (c_q) pc_d = target;
                    OpSlp: state_d = StSleep;
                    default: ;
                endcase
                if (upd_z) z_d = (acc_d == '0);
            end
            StSleep: if (wakeup) state_d = StFetch;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            acc_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            z_q     <= z_d;
            c_q     <= c_d;
            if (state_q == StDecode) ir_q <= imem.imem_rdata;
            if (reg_we) regs_q[sel] <= acc_q;
        end
    end

    // Strobe is gated by reset so no read is issued while the core is held.
    assign imem.imem_en   = reset_n && (state_q == StFetch);
    assign imem.imem_addr = pc_q;
    assign acc            = acc_q;
    assign pc             = pc_q;
    assign state          = state_q;
    assign flag_z         = z_q;
    assign flag_c         = c_q;
    assign sleeping       = (state_q == StSleep);
    assign instr_retired  = (state_q == StExecute);
endmodule
